program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, number of 8-bit program memory locations.
REQ-002 Parameter ADDR_W, default 10, memory address width; MEM_DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a new load at address 0.
REQ-006 in_data  input  8  incoming bytecode byte.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  program-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  8  write data.
REQ-012 byte_count  output  ADDR_W+1  number of bytes written in the current load.
REQ-013 load_done  output  1  well-formed program loaded.
REQ-014 load_error  output  1  load aborted.
REQ-015 err_code  output  2  00 none, 01 illegal opcode, 10 memory overflow.
REQ-016 cpu_enable  output  1  enable to the downstream processor.

Function
REQ-017 States SHALL be IDLE, OPC, OPR1, OPR2, OPR3, DONE, ERROR.
REQ-018 A byte is accepted when in_valid and in_ready are both high on a posedge.
REQ-019 in_ready SHALL be high only in OPC, OPR1, OPR2, OPR3.
REQ-020 An accepted byte SHALL appear as mem_we=1, mem_addr=byte_count (pre-increment), mem_wdata=byte in the following cycle; mem_we SHALL otherwise be 0.
REQ-021 byte_count SHALL increment by 1 per accepted byte.
REQ-022 start in IDLE, DONE or ERROR -> OPC; byte_count, load_done, load_error, err_code, cpu_enable cleared; start in OPC/OPR1-3 ignored.
REQ-023 OPC: accepted 0x02 -> OPR1 with 3 operands expected; 0x01 -> OPR1 with 2 expected; 0xFF -> DONE; any other -> ERROR, err_code=01.
REQ-024 OPR1 -> OPR2 on accepted byte; OPR2 -> OPC if 2 operands expected, else -> OPR3; OPR3 -> OPC.
REQ-025 Operand bytes SHALL be written unchecked (any value legal).
REQ-026 Illegal opcode byte SHALL still be written to memory.
REQ-027 Byte accepted at address MEM_DEPTH-1 that does not drive the FSM to DONE -> ERROR, err_code=10 (byte written).
REQ-028 0xFF accepted at address MEM_DEPTH-1 in OPC -> DONE (legal).
REQ-029 If an illegal opcode is accepted at address MEM_DEPTH-1, err_code SHALL be 01 (opcode check wins).
REQ-030 DONE: load_done=1, cpu_enable=1, held until start or rst.
REQ-031 ERROR: load_error=1, cpu_enable=0, err_code held until start or rst.
REQ-032 load_done and load_error SHALL never be high together.
REQ-033 in_valid while in_ready low SHALL have no effect.

Reset
REQ-034 rst high at posedge: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0, load_done=0, load_error=0, err_code=00, cpu_enable=0.
REQ-035 rst SHALL override start and in_valid in the same cycle.
REQ-036 rst mid-load SHALL abort; no mem_we in the cycle after rst even if a byte was accepted the cycle before.

Verification
REQ-037 start; bytes 02,05,03,04,01,07,09,FF -> 8 writes at addr 0..7 with same data, load_done=1, cpu_enable=1, byte_count=8.
REQ-038 start; bytes 01,00,2A,33 -> 4 writes, load_error=1, err_code=01, cpu_enable=0, in_ready=0 afterwards.
REQ-039 start; 1024 bytes alternating 01,00,00 never hitting FF -> byte 1023 written, err_code=10; variant with FF at addr 1023 in OPC -> load_done=1, byte_count=1024.
REQ-040 start; 02,01 then rst -> all outputs at reset values next cycle, no further mem_we; new start reloads from addr 0.
REQ-041 in_valid toggled randomly with gaps during load of 02,05,03,04,FF; start pulsed mid-load -> ignored, identical writes and load_done as gap-free run.
REQ-042 After DONE, start pulse -> cpu_enable drops next cycle, byte_count=0, state OPC.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - bytecode loader that parses a byte stream into program memory
// Opcodes 0x01/0x02 take 2/3 operands, 0xFF terminates; anything else or a full memory aborts.
module program_loader #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   byte_count,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code,
  output logic              cpu_enable
);

  typedef enum logic [2:0] {IDLE, OPC, OPR1, OPR2, OPR3, DONE, ERROR} state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_DEPTH - 1);

  state_t     state;
  state_t     nxt;
  logic [1:0] nxt_err;
  logic       three_ops;
  logic       accept;
  logic       at_last;

  assign in_ready = (state == OPC) || (state == OPR1) || (state == OPR2) || (state == OPR3);
  assign accept   = in_valid && in_ready;
  assign at_last  = (byte_count == LAST_ADDR);

  // Next state for an accepted byte; opcode check outranks the overflow check.
  always_comb begin
    nxt     = state;
    nxt_err = 2'b00;
    case (state)
      OPC: begin
        if (in_data == 8'hFF) begin
          nxt = DONE;
        end else if (in_data == 8'h01 || in_data == 8'h02) begin
          nxt = OPR1;
        end else begin
          nxt     = ERROR;
          nxt_err = 2'b01;
        end
      end
      OPR1:    nxt = OPR2;
      OPR2:    nxt = three_ops ? OPR3 : OPC;
      OPR3:    nxt = OPC;
      default: nxt = state;
    endcase
    if (at_last && nxt != DONE && nxt != ERROR) begin
      nxt     = ERROR;
      nxt_err = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      three_ops  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_count <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      err_code   <= 2'b00;
      cpu_enable <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start && (state == IDLE || state == DONE || state == ERROR)) begin
        state      <= OPC;
        byte_count <= '0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        err_code   <= 2'b00;
        cpu_enable <= 1'b0;
      end else if (accept) begin
        mem_we     <= 1'b1;
        mem_addr   <= byte_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        byte_count <= byte_count + 1'b1;
        state      <= nxt;
        if (state == OPC) begin
          three_ops <= (in_data == 8'h02);
        end
        if (nxt == DONE) begin
          load_done  <= 1'b1;
          cpu_enable <= 1'b1;
        end else if (nxt == ERROR) begin
          load_error <= 1'b1;
          err_code   <= nxt_err;
          cpu_enable <= 1'b0;
        end
      end
    end
  end

endmodule
